// File: rtl/bios_loader.sv
// bios_loader: host-side initiator for the BIOS UART command protocol.
// Sends "nop", then "write" with a 4-byte little-endian size, a 4-byte
// little-endian address and the image bytes read from a local ROM, then
// an optional "boot". Every acknowledge byte from the BIOS is checked.
//
// Optional feature macro: BIOS_LOADER_TIMEOUT_EN
//   Defined: each reply wait aborts with o_err_code=8'hFF after
//   TIMEOUT_CYCLES enabled cycles with no RX transfer.
//   Undefined: reply waits are unbounded and no timeout counter exists.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   clk_en            global enable; state and handshakes advance only when high
//   i_start           one-cycle start pulse, ignored while busy
//   i_size/i_base_addr/i_boot  job parameters, sampled at start
//   o_rom_rd/o_rom_addr/i_rom_data  ROM port, data valid the cycle after o_rom_rd
//   o_data/o_valid/i_out_ready      TX byte stream
//   i_data/i_valid/o_in_ready       RX byte stream
//   o_busy, o_done, o_error, o_err_code  status (done/error/code are sticky)
//
// State table:
//   IDLE     | waiting for i_start
//   TX_NOP   | sending 'n','o','p'
//   WAIT_N   | expecting 'N'
//   TX_WRITE | sending 'w','r','i','t','e'
//   WAIT_W   | expecting 'W'
//   TX_SIZE  | sending size, LSB first
//   TX_ADDR  | sending address, LSB first
//   ROM_RD   | ROM read strobe for current index
//   ROM_WAIT | capture ROM byte
//   TX_DATA  | sending captured image byte
//   TX_BOOT  | sending 'b','o','o','t'
//   WAIT_B   | expecting 'B'
//   DONE     | success, back to IDLE
//   ERROR    | abort, back to IDLE
module bios_loader #(
  parameter int ROM_AW         = 12,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              i_start,
  input  logic [31:0]       i_size,
  input  logic [31:0]       i_base_addr,
  input  logic              i_boot,
  output logic              o_rom_rd,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [7:0]        i_rom_data,
  output logic [7:0]        o_data,
  output logic              o_valid,
  input  logic              i_out_ready,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  output logic              o_in_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [7:0]        o_err_code
);

  typedef enum logic [3:0] {
    S_IDLE, S_TX_NOP, S_WAIT_N, S_TX_WRITE, S_WAIT_W, S_TX_SIZE, S_TX_ADDR,
    S_ROM_RD, S_ROM_WAIT, S_TX_DATA, S_TX_BOOT, S_WAIT_B, S_DONE, S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  state_t      w_after_data;
  logic [2:0]  r_cmd_idx;
  logic [1:0]  r_byte_sel;
  logic [31:0] r_idx;
  logic [31:0] w_idx_inc;
  logic [31:0] r_size;
  logic [31:0] r_addr;
  logic        r_boot;
  logic [7:0]  r_rom_byte;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [7:0]  r_err_code;
  logic [7:0]  w_err_code;
  logic        w_is_wait;
  logic        w_tx_xfer;
  logic        w_rx_xfer;

  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] sel);
    case (sel)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
  endfunction

  assign w_is_wait  = (r_state == S_WAIT_N) || (r_state == S_WAIT_W) || (r_state == S_WAIT_B);
  assign o_in_ready = w_is_wait;
  assign o_valid    = (r_state == S_TX_NOP)  || (r_state == S_TX_WRITE) ||
                      (r_state == S_TX_SIZE) || (r_state == S_TX_ADDR)  ||
                      (r_state == S_TX_DATA) || (r_state == S_TX_BOOT);
  // Handshakes count only on enabled cycles; the partner shares clk_en.
  assign w_tx_xfer  = o_valid & i_out_ready;
  assign w_rx_xfer  = o_in_ready & i_valid;
  assign w_idx_inc  = r_idx + 32'd1;

  assign o_rom_rd   = (r_state == S_ROM_RD);
  assign o_rom_addr = r_idx[ROM_AW-1:0];
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_error    = r_error;
  assign o_err_code = r_err_code;

`ifdef BIOS_LOADER_TIMEOUT_EN
  logic [31:0] r_tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= '0;
    end else if (clk_en) begin
      // Held at zero outside the waits, so every wait starts from zero.
      if (!w_is_wait)
        r_tmo <= '0;
      else if (!w_rx_xfer)
        r_tmo <= r_tmo + 32'd1;
    end
  end
`endif

  always_comb begin
    w_next       = r_state;
    w_err_code   = i_data;
    w_after_data = r_boot ? S_TX_BOOT : S_DONE;
    case (r_state)
      S_IDLE:     if (i_start) w_next = S_TX_NOP;
      S_TX_NOP:   if (w_tx_xfer && r_cmd_idx == 3'd2) w_next = S_WAIT_N;
      S_WAIT_N:   if (w_rx_xfer) w_next = (i_data == 8'h4E) ? S_TX_WRITE : S_ERROR;
      S_TX_WRITE: if (w_tx_xfer && r_cmd_idx == 3'd4) w_next = S_WAIT_W;
      S_WAIT_W:   if (w_rx_xfer) w_next = (i_data == 8'h57) ? S_TX_SIZE : S_ERROR;
      S_TX_SIZE:  if (w_tx_xfer && r_byte_sel == 2'd3) w_next = S_TX_ADDR;
      S_TX_ADDR:  if (w_tx_xfer && r_byte_sel == 2'd3)
                    w_next = (r_size != 32'd0) ? S_ROM_RD : w_after_data;
      S_ROM_RD:   w_next = S_ROM_WAIT;
      S_ROM_WAIT: w_next = S_TX_DATA;
      S_TX_DATA:  if (w_tx_xfer) w_next = (w_idx_inc == r_size) ? w_after_data : S_ROM_RD;
      S_TX_BOOT:  if (w_tx_xfer && r_cmd_idx == 3'd3) w_next = S_WAIT_B;
      S_WAIT_B:   if (w_rx_xfer) w_next = (i_data == 8'h42) ? S_DONE : S_ERROR;
      S_DONE:     w_next = S_IDLE;
      S_ERROR:    w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
`ifdef BIOS_LOADER_TIMEOUT_EN
    if (w_is_wait && !w_rx_xfer && r_tmo == 32'(TIMEOUT_CYCLES - 1)) begin
      w_next     = S_ERROR;
      w_err_code = 8'hFF;
    end
`endif
  end

  always_comb begin
    o_data = 8'h00;
    case (r_state)
      S_TX_NOP:
        case (r_cmd_idx)
          3'd0:    o_data = "n";
          3'd1:    o_data = "o";
          default: o_data = "p";
        endcase
      S_TX_WRITE:
        case (r_cmd_idx)
          3'd0:    o_data = "w";
          3'd1:    o_data = "r";
          3'd2:    o_data = "i";
          3'd3:    o_data = "t";
          default: o_data = "e";
        endcase
      S_TX_SIZE: o_data = sel_byte(r_size, r_byte_sel);
      S_TX_ADDR: o_data = sel_byte(r_addr, r_byte_sel);
      S_TX_DATA: o_data = r_rom_byte;
      S_TX_BOOT:
        case (r_cmd_idx)
          3'd0:    o_data = "b";
          3'd1:    o_data = "o";
          3'd2:    o_data = "o";
          default: o_data = "t";
        endcase
      default:   o_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cmd_idx  <= '0;
      r_byte_sel <= '0;
      r_idx      <= '0;
      r_size     <= '0;
      r_addr     <= '0;
      r_boot     <= 1'b0;
      r_rom_byte <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= '0;
    end else if (clk_en) begin
      r_state <= w_next;
      // Both byte counters restart on every state change.
      if (w_next != r_state) begin
        r_cmd_idx  <= '0;
        r_byte_sel <= '0;
      end else if (w_tx_xfer) begin
        r_cmd_idx  <= r_cmd_idx + 3'd1;
        r_byte_sel <= r_byte_sel + 2'd1;
      end
      if (r_state == S_IDLE && i_start) begin
        r_size     <= i_size;
        r_addr     <= i_base_addr;
        r_boot     <= i_boot;
        r_idx      <= '0;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
        r_error    <= 1'b0;
        r_err_code <= '0;
      end
      if (r_state == S_ROM_WAIT)
        r_rom_byte <= i_rom_data;
      if (r_state == S_TX_DATA && w_tx_xfer)
        r_idx <= w_idx_inc;
      if (w_next == S_DONE && r_state != S_DONE) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
      if (w_next == S_ERROR && r_state != S_ERROR) begin
        r_error    <= 1'b1;
        r_busy     <= 1'b0;
        r_err_code <= w_err_code;
      end
    end
  end

endmodule

// File: tb/tb_bios_loader.sv
module tb_bios_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_en = 1'b0;
  logic          i_start = 1'b0;
  logic [31:0]   i_size = '0;
  logic [31:0]   i_base_addr = '0;
  logic          i_boot = 1'b0;
  logic          o_rom_rd;
  logic [AW-1:0] o_rom_addr;
  logic [7:0]    i_rom_data = '0;
  logic [7:0]    o_data;
  logic          o_valid;
  logic          i_out_ready = 1'b0;
  logic [7:0]    i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_in_ready;
  logic          o_busy;
  logic          o_done;
  logic          o_error;
  logic [7:0]    o_err_code;

  always #5 clk = ~clk;

  bios_loader #(
    .ROM_AW(AW)
`ifdef BIOS_LOADER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_start(i_start), .i_size(i_size),
    .i_base_addr(i_base_addr), .i_boot(i_boot), .o_rom_rd(o_rom_rd),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data), .o_data(o_data),
    .o_valid(o_valid), .i_out_ready(i_out_ready), .i_data(i_data),
    .i_valid(i_valid), .o_in_ready(o_in_ready), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error), .o_err_code(o_err_code)
  );

  typedef struct {
    logic [31:0]     size;
    logic [31:0]     addr;
    logic            boot;
    int              nrep;
    logic [2:0][7:0] rep;
    int              mode;
    logic            exp_done;
    logic            exp_err;
    logic [7:0]      exp_code;
    int              exp_len;
    int              exp_reads;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] rom[16];
  logic [7:0] rep_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         mode = 0;
  int         ph = 0;
  int         rom_reads = 0;
  logic       pend_pop = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  // Synchronous ROM: data appears the cycle after the read strobe.
  always @(posedge clk) if (o_rom_rd) i_rom_data <= rom[o_rom_addr];

  // BIOS side: drives enables and RX bytes at negedge, predicts transfers
  // at the following posedge, and checks TX data is held while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      pend_pop  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (!(o_valid && o_data == prev_data)) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b data=%02h required valid=1 data=%02h",
                   o_valid, o_data, prev_data);
        end
      end
      if (pend_pop && rep_q.size() > 0) void'(rep_q.pop_front());
      ph++;
      if (mode == 1) begin
        clk_en      = ~ph[1];
        i_out_ready = ~ph[0];
      end else begin
        clk_en      = 1'b1;
        i_out_ready = 1'b1;
      end
      i_valid = (rep_q.size() > 0);
      i_data  = i_valid ? rep_q[0] : 8'h00;
      if (clk_en && o_valid && i_out_ready) tx_q.push_back(o_data);
      if (clk_en && o_rom_rd) rom_reads++;
      pend_pop  = clk_en && i_valid && o_in_ready;
      prev_hold = o_valid && !(clk_en && i_out_ready);
      prev_data = o_data;
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[31:24]);
  endtask

  // Reference byte stream: stops after the command whose reply is wrong.
  task automatic build_exp(input vec_t v);
    exp_q.delete();
    push_str("nop");
    if (v.nrep < 1 || v.rep[0] != 8'h4E) return;
    push_str("write");
    if (v.nrep < 2 || v.rep[1] != 8'h57) return;
    push_word(v.size);
    push_word(v.addr);
    for (int i = 0; i < int'(v.size); i++) exp_q.push_back(rom[i % 16]);
    if (v.boot) push_str("boot");
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic start_job(input vec_t v);
    int n;
    rep_q.delete();
    for (int k = 0; k < v.nrep; k++) rep_q.push_back(v.rep[k]);
    tx_q.delete();
    rom_reads   = 0;
    mode        = v.mode;
    i_size      = v.size;
    i_base_addr = v.addr;
    i_boot      = v.boot;
    @(negedge clk);
    i_start = 1'b1;
    n = 0;
    while (!o_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    i_start = 1'b0;
    check("busy_after_start", {31'd0, o_busy}, 32'd1);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   n;
    v = vecs[idx];
    start_job(v);
    n = 0;
    while (o_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("job_finished", {31'd0, o_busy}, 32'd0);
    repeat (10) @(negedge clk);
    build_exp(v);
    check("done", {31'd0, o_done}, {31'd0, v.exp_done});
    check("error", {31'd0, o_error}, {31'd0, v.exp_err});
    check("err_code", {24'd0, o_err_code}, {24'd0, v.exp_code});
    check("rom_reads", rom_reads, v.exp_reads);
    check("tx_len", tx_q.size(), v.exp_len);
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL tx_byte vec %0d idx %0d: got %02h required %02h", idx, i, tx_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) rom[i] = 8'(i * 17 + 5);
    rom[0] = 8'hA1; rom[1] = 8'hB2; rom[2] = 8'hC3;

    //          size    addr          boot nrep  rep{r2,r1,r0}            mode done err code  len reads
    vecs[0] = '{32'd3,  32'h0000_0100, 1'b0, 2, {8'h00, 8'h57, 8'h4E}, 0, 1'b1, 1'b0, 8'h00, 19, 3};
    vecs[1] = '{32'd0,  32'h0000_0200, 1'b1, 3, {8'h42, 8'h57, 8'h4E}, 0, 1'b1, 1'b0, 8'h00, 20, 0};
    vecs[2] = '{32'd3,  32'h0000_0100, 1'b0, 1, {8'h00, 8'h00, 8'h45}, 0, 1'b0, 1'b1, 8'h45, 3,  0};
    vecs[3] = '{32'd3,  32'h0000_0100, 1'b0, 2, {8'h00, 8'h57, 8'h4E}, 1, 1'b1, 1'b0, 8'h00, 19, 3};
    vecs[4] = '{32'd3,  32'h0000_0100, 1'b0, 2, {8'h00, 8'h58, 8'h4E}, 0, 1'b0, 1'b1, 8'h58, 8,  0};
    vecs[5] = '{32'd2,  32'hDEAD_BEEF, 1'b1, 3, {8'h30, 8'h57, 8'h4E}, 0, 1'b0, 1'b1, 8'h30, 22, 2};
    vecs[6] = '{32'd18, 32'h0000_2000, 1'b1, 3, {8'h42, 8'h57, 8'h4E}, 1, 1'b1, 1'b0, 8'h00, 38, 18};
    vecs[7] = '{32'd1,  32'h1234_5678, 1'b0, 2, {8'h00, 8'h57, 8'h4E}, 0, 1'b1, 1'b0, 8'h00, 17, 1};

    #1;
    check("reset_outputs",
          {8'd0, o_rom_rd, o_rom_addr, o_data, o_valid, o_in_ready, o_busy, o_done, o_error, o_err_code},
          32'd0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset after the second data byte: immediate abort, no trailing bytes.
    start_job(vecs[0]);
    n = 0;
    while (tx_q.size() < 18 && n < 500) begin
      @(negedge clk); #2;
      n++;
    end
    check("reached_data_byte2", tx_q.size(), 18);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("midrun_reset_outputs",
          {8'd0, o_rom_rd, o_rom_addr, o_data, o_valid, o_in_ready, o_busy, o_done, o_error, o_err_code},
          32'd0);
    repeat (5) @(posedge clk);
    check("no_trailing_bytes", tx_q.size(), 18);
    #1 rst = 1'b1;
    run_vec(0);

`ifdef BIOS_LOADER_TIMEOUT_EN
    begin
      vec_t t;
      t = '{32'd3, 32'h0000_0100, 1'b0, 0, {8'h00, 8'h00, 8'h00}, 0, 1'b0, 1'b1, 8'hFF, 3, 0};
      start_job(t);
      n = 0;
      while (tx_q.size() < 3 && n < 100) begin
        @(negedge clk); #2;
        n++;
      end
      @(posedge clk);
      n = 0;
      while (n < 200) begin
        @(posedge clk); n++;
        #1;
        if (o_error) break;
      end
      check("timeout_cycles", n, 50);
      check("timeout_code", {24'd0, o_err_code}, 32'h0000_00FF);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bios_loader.md
Name: bios_loader

Overview:
- Host-side initiator for the BIOS UART command protocol. Replays a fixed command sequence over an 8-bit AXI-stream byte link: "nop" probe, then "write" carrying an image held in a local ROM, then an optional "boot".
- Checks every acknowledge byte the BIOS returns.
- Used for on-chip self-load and as the bench-side driver for the BIOS.

Parameters:
- ROM_AW, 12, ROM byte-address width.
- TIMEOUT_CYCLES, 100000, clk_en-qualified cycles allowed per reply wait. Only used with BIOS_LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- clk_en  in  1  global enable; all state advances only when high
- i_start  in  1  one-cycle pulse; begins the sequence when idle
- i_size  in  32  image length in bytes; sampled at start
- i_base_addr  in  32  BIOS RAM destination address; sampled at start
- i_boot  in  1  issue "boot" after the write; sampled at start
- o_rom_rd  out  1  ROM read strobe
- o_rom_addr  out  ROM_AW  ROM byte address
- i_rom_data  in  8  ROM data, valid the cycle after o_rom_rd
- o_data  out  8  TX byte
- o_valid  out  1  TX valid
- i_out_ready  in  1  TX ready
- i_data  in  8  RX byte
- i_valid  in  1  RX valid
- o_in_ready  out  1  RX ready
- o_busy  out  1  sequence in progress
- o_done  out  1  sticky; sequence completed OK
- o_error  out  1  sticky; sequence aborted
- o_err_code  out  8  offending reply byte, or 8'hFF on timeout

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, except o_err_code=0.
- Handshakes:
  - TX byte transfers when o_valid & i_out_ready. While o_valid is high, o_data holds stable until accepted.
  - RX byte transfers when i_valid & o_in_ready. o_in_ready is high only in WAIT_* states.
  - RX bytes arriving outside WAIT_* are not consumed.
- States and transitions:
  - IDLE: on i_start, latch size, addr and boot; clear o_done, o_error and o_err_code; set o_busy; go to TX_NOP. i_start while busy is ignored.
  - TX_NOP: send 'n','o','p' → WAIT_N.
  - WAIT_N: expect 'N' → TX_WRITE.
  - TX_WRITE: send 'w','r','i','t','e' → WAIT_W.
  - WAIT_W: expect 'W' → TX_SIZE.
  - TX_SIZE: send size, 4 bytes, little-endian.
  - TX_ADDR: send addr, 4 bytes, little-endian.
  - Data phase, if size≠0 → ROM_RD:
    - ROM_RD: pulse o_rom_rd with o_rom_addr = byte index (low ROM_AW bits; wraps modulo 2^ROM_AW).
    - ROM_WAIT: capture i_rom_data.
    - TX_DATA: send the captured byte; the index counter increments on acceptance.
    - When index == size, or immediately after TX_ADDR if size==0: go to TX_BOOT if boot is latched, else DONE.
  - TX_BOOT: send 'b','o','o','t' → WAIT_B.
  - WAIT_B: expect 'B' → DONE.
  - DONE: o_done=1, o_busy=0 → IDLE.
  - ERROR: o_error=1, o_busy=0, o_err_code=received byte → IDLE.
- Any unexpected byte in a WAIT_* state (e.g. '0', 'E', 'X') goes to ERROR.
- Command-byte index uses a 3-bit counter. Size/addr byte select uses a 2-bit counter.
- Data index counter is 32 bits, compared against the latched size. Sizes up to 2^32-1 are legal.
- Throughput: at most one data byte per 3 enabled cycles (ROM_RD, ROM_WAIT, TX).
- When clk_en=0, the FSM, counters and ROM capture freeze; outputs hold.
- Reset mid-sequence aborts immediately with no trailing bytes. o_done and o_error both return to 0.

Optional Feature:
- Macro BIOS_LOADER_TIMEOUT_EN.
- Defined: a counter clears on entry to each WAIT_* state and increments on every enabled cycle without an RX transfer. Reaching TIMEOUT_CYCLES goes to ERROR with o_err_code=8'hFF.
- Not defined: WAIT_* states wait indefinitely; no counter is instantiated.

Test Plan:
- Always-ready BIOS model, start with size=3, addr=0x100, boot=0, ROM[0..2]=A1,B2,C3:
  - TX stream must be: n o p, then w r i t e, then 03 00 00 00, then 00 01 00 00, then A1 B2 C3.
  - With replies 'N' then 'W': o_done=1, o_error=0.
- size=0, boot=1, replies 'N','W','B': TX is the nop, write, size and address sequence, then 'b','o','o','t', with no ROM reads; o_done=1.
- Reply 'E' to "nop": o_error=1, o_err_code=0x45; no further TX bytes; a following start restarts cleanly.
- i_out_ready toggling 1-0-1 each cycle and clk_en at 50%: byte stream identical to the first scenario; o_data stable whenever o_valid=1 and i_out_ready=0.
- rst asserted after the 2nd data byte: all outputs 0 asynchronously; after rst release, a new start re-sends from 'n'.
- With BIOS_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=50, no reply to "nop": o_error=1, o_err_code=0xFF, 50 enabled cycles after the 'p' transfer.
